// File: rtl/chime_ctrl_if.sv
// Time, control and chime-output bundle between the BCD time counters,
// the chime controller and the buzzer driver.
interface chime_ctrl_if;
    logic       sec_tick;
    logic [3:0] i_hr1;
    logic [3:0] i_hr0;
    logic [3:0] i_min1;
    logic [3:0] i_min0;
    logic [3:0] i_sec1;
    logic [3:0] i_sec0;
    logic       use_dang;
    logic       strike_en;
    logic       alarm;
    logic       alarm2;
    logic       busy;

    modport master (
        output sec_tick, i_hr1, i_hr0, i_min1, i_min0, i_sec1, i_sec0,
        output use_dang, strike_en,
        input  alarm, alarm2, busy
    );

    modport slave (
        input  sec_tick, i_hr1, i_hr0, i_min1, i_min0, i_sec1, i_sec0,
        input  use_dang, strike_en,
        output alarm, alarm2, busy
    );
endinterface

// File: rtl/chime_ctrl.sv
// Hourly chime controller: configurable pre-hour beeps in minute 59 plus a
// top-of-hour output that is either a single pulse or an hour-count strike.
module chime_ctrl #(
    parameter int PRE_BEEPS  = 5,
    parameter int STRIKE_ON  = 1,
    parameter int STRIKE_OFF = 1,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    chime_ctrl_if.slave bus
);
    localparam int               WIN_START = 60 - 2 * PRE_BEEPS;
    localparam logic [7:0]       WIN_LO    = 8'(WIN_START);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(STRIKE_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(STRIKE_OFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return 8'(tens) * 8'd10 + 8'(units);
    endfunction

    // Hour in 12-h form (00 and 12 both strike 12); 0 flags an unusable hour.
    function automatic logic [3:0] strike_count(input logic [3:0] h1, input logic [3:0] h0);
        logic [7:0] h24;
        h24 = bcd_to_bin(h1, h0);
        if (h1 > 4'd9 || h0 > 4'd9 || h24 > 8'd23)
            return 4'd0;
        if (h24 == 8'd0 || h24 == 8'd12)
            return 4'd12;
        if (h24 > 8'd12)
            return 4'(h24 - 8'd12);
        return 4'(h24);
    endfunction

    state_t           state,     state_nxt;
    logic [3:0]       strikes,   strikes_nxt;
    logic [CNT_W-1:0] ticks,     ticks_nxt;
    logic             m_p1;
    logic             alarm_p1,  alarm2_p1, busy_p1;
    logic             alarm_nxt, alarm2_nxt;

    logic [7:0] sec_bin;
    logic       min59;
    logic       top_match;
    logic       trigger;
    logic [3:0] n_strikes;

    assign sec_bin   = bcd_to_bin(bus.i_sec1, bus.i_sec0);
    assign min59     = (bus.i_min1 == 4'd5) && (bus.i_min0 == 4'd9);
    assign top_match = (bus.i_min1 == 4'd0) && (bus.i_min0 == 4'd0) &&
                       (bus.i_sec1 == 4'd0) && (bus.i_sec0 == 4'd0);
    assign trigger   = top_match && !m_p1;
    assign n_strikes = strike_count(bus.i_hr1, bus.i_hr0);

    // Beeps land on even offsets into the window, so parity matches WIN_LO.
    assign alarm_nxt = bus.use_dang && min59 &&
                       (sec_bin >= WIN_LO) && (sec_bin <= 8'd59) &&
                       (sec_bin[0] == WIN_LO[0]);

    always_comb begin
        state_nxt   = state;
        strikes_nxt = strikes;
        ticks_nxt   = ticks;
        if (!bus.use_dang) begin
            state_nxt   = IDLE;
            strikes_nxt = 4'd0;
            ticks_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.strike_en && trigger && n_strikes != 4'd0) begin
                        state_nxt   = HI;
                        strikes_nxt = n_strikes;
                        ticks_nxt   = '0;
                    end
                end
                HI: begin
                    if (bus.sec_tick) begin
                        if (ticks == ON_LAST) begin
                            ticks_nxt = '0;
                            state_nxt = LO;
                        end else begin
                            ticks_nxt = ticks + CNT_W'(1);
                        end
                    end
                end
                LO: begin
                    if (bus.sec_tick) begin
                        if (ticks == OFF_LAST) begin
                            ticks_nxt   = '0;
                            strikes_nxt = strikes - 4'd1;
                            state_nxt   = (strikes == 4'd1) ? IDLE : HI;
                        end else begin
                            ticks_nxt = ticks + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    strikes_nxt = 4'd0;
                    ticks_nxt   = '0;
                end
            endcase
        end

        // A running strike owns alarm2 until it returns to IDLE, whatever strike_en does.
        if (state == IDLE && !bus.strike_en)
            alarm2_nxt = bus.use_dang && top_match;
        else
            alarm2_nxt = (state_nxt == HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            strikes   <= 4'd0;
            ticks     <= '0;
            m_p1      <= 1'b0;
            alarm_p1  <= 1'b0;
            alarm2_p1 <= 1'b0;
            busy_p1   <= 1'b0;
        end else begin
            state     <= state_nxt;
            strikes   <= strikes_nxt;
            ticks     <= ticks_nxt;
            m_p1      <= top_match;
            alarm_p1  <= alarm_nxt;
            alarm2_p1 <= alarm2_nxt;
            busy_p1   <= (state_nxt != IDLE);
        end
    end

    assign bus.alarm  = alarm_p1;
    assign bus.alarm2 = alarm2_p1;
    assign bus.busy   = busy_p1;
endmodule

// File: tb/tb_chime_ctrl.sv
// Bench for chime_ctrl: two instances (default and PRE_BEEPS=3/ON=2/OFF=3)
// driven with identical time, checked against a tick-counting reference model.
module tb_chime_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    chime_ctrl_if if0();
    chime_ctrl_if if1();

    chime_ctrl #(.PRE_BEEPS(5), .STRIKE_ON(1), .STRIKE_OFF(1), .CNT_W(4))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    chime_ctrl #(.PRE_BEEPS(3), .STRIKE_ON(2), .STRIKE_OFF(3), .CNT_W(3))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    // Stimulus state: wall-clock time plus optional raw (possibly invalid) hour digits.
    int         hh = 12, mm = 0, ss = 0;
    bit         bad_hr = 1'b0;
    logic [3:0] bad_h1 = 4'd0, bad_h0 = 4'd0;
    logic       tick = 1'b0, dang = 1'b1, sen = 1'b0;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
    int         tcnt = 0;

    int checks = 0;
    int failures = 0;

    // Reference model: a strike is "k sec_ticks into a sequence of total ticks".
    int P_PB[2]  = '{5, 3};
    int P_ON[2]  = '{1, 2};
    int P_OFF[2] = '{1, 3};
    bit active[2] = '{0, 0};
    int k[2]      = '{0, 0};
    int total[2]  = '{0, 0};
    bit ea[2]     = '{0, 0};
    bit ea2[2]    = '{0, 0};
    bit eb[2]     = '{0, 0};
    bit m_prev    = 1'b0;

    typedef struct {
        int hh;
        int mm;
        int ss;
        bit ea0;
        bit ea2_0;
        bit ea1;
    } vec_t;
    vec_t tbl[15];

    function automatic int n_of(input logic [3:0] h1, input logic [3:0] h0);
        int h;
        if (h1 > 4'd9 || h0 > 4'd9) return 0;
        h = 10 * int'(h1) + int'(h0);
        if (h > 23) return 0;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic drive();
        cur_h1 = bad_hr ? bad_h1 : 4'(hh / 10);
        cur_h0 = bad_hr ? bad_h0 : 4'(hh % 10);
        cur_m1 = 4'(mm / 10);
        cur_m0 = 4'(mm % 10);
        cur_s1 = 4'(ss / 10);
        cur_s0 = 4'(ss % 10);
        if0.sec_tick = tick;   if1.sec_tick = tick;
        if0.i_hr1 = cur_h1;    if1.i_hr1 = cur_h1;
        if0.i_hr0 = cur_h0;    if1.i_hr0 = cur_h0;
        if0.i_min1 = cur_m1;   if1.i_min1 = cur_m1;
        if0.i_min0 = cur_m0;   if1.i_min0 = cur_m0;
        if0.i_sec1 = cur_s1;   if1.i_sec1 = cur_s1;
        if0.i_sec0 = cur_s0;   if1.i_sec0 = cur_s0;
        if0.use_dang = dang;   if1.use_dang = dang;
        if0.strike_en = sen;   if1.strike_en = sen;
    endtask

    task automatic model_update();
        int s, n, w, per;
        bit m, trig, m59, was;
        s   = 10 * int'(cur_s1) + int'(cur_s0);
        m59 = (cur_m1 == 4'd5 && cur_m0 == 4'd9);
        m   = (cur_m1 == 4'd0 && cur_m0 == 4'd0 && cur_s1 == 4'd0 && cur_s0 == 4'd0);
        trig = m && !m_prev;
        n   = n_of(cur_h1, cur_h0);
        for (int d = 0; d < 2; d++) begin
            per = P_ON[d] + P_OFF[d];
            w   = 60 - 2 * P_PB[d];
            if (rst) begin
                active[d] = 0; k[d] = 0; ea[d] = 0; ea2[d] = 0; eb[d] = 0;
            end else begin
                was = active[d];
                if (!dang) begin
                    active[d] = 0;
                end else if (active[d]) begin
                    if (tick) begin
                        k[d]++;
                        if (k[d] == total[d]) active[d] = 0;
                    end
                end else if (sen && trig && n != 0) begin
                    active[d] = 1;
                    k[d] = 0;
                    total[d] = n * per;
                end
                ea[d]  = dang && m59 && s >= w && s <= 59 && ((s - w) % 2 == 0);
                ea2[d] = (was || active[d]) ? (active[d] && (k[d] % per) < P_ON[d])
                                            : (!sen && dang && m);
                eb[d]  = active[d];
            end
        end
        m_prev = rst ? 1'b0 : m;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_update();
        #1;
        chk("d0_alarm",  if0.alarm,  ea[0]);
        chk("d0_alarm2", if0.alarm2, ea2[0]);
        chk("d0_busy",   if0.busy,   eb[0]);
        chk("d1_alarm",  if1.alarm,  ea[1]);
        chk("d1_alarm2", if1.alarm2, ea2[1]);
        chk("d1_busy",   if1.busy,   eb[1]);
    endtask

    task automatic advance();
        ss++;
        if (ss == 60) begin
            ss = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                if (!bad_hr) hh = (hh + 1) % 24;
            end
        end
    endtask

    task automatic walk1(input int p);
        tick = ((tcnt % p) == p - 1);
        step();
        if (tick) advance();
        tcnt++;
        tick = 1'b0;
    endtask

    task automatic run_pulses(input int n, input int p, output int pulses, output bit busy_seen);
        logic prev;
        pulses = 0;
        busy_seen = 0;
        prev = if0.alarm2;
        for (int i = 0; i < n; i++) begin
            walk1(p);
            if (if0.alarm2 && !prev) pulses++;
            if (if0.busy) busy_seen = 1;
            prev = if0.alarm2;
        end
    endtask

    task automatic start_at(input int h, input int m, input int s);
        hh = h; mm = m; ss = s; tcnt = 0;
    endtask

    initial begin
        int  pulses, more, r;
        bit  bseen;
        logic prev;
        bit  reached;

        tbl[0]  = '{12, 59, 48, 0, 0, 0};
        tbl[1]  = '{12, 59, 49, 0, 0, 0};
        tbl[2]  = '{12, 59, 50, 1, 0, 0};
        tbl[3]  = '{12, 59, 51, 0, 0, 0};
        tbl[4]  = '{12, 59, 52, 1, 0, 0};
        tbl[5]  = '{12, 59, 53, 0, 0, 0};
        tbl[6]  = '{12, 59, 54, 1, 0, 1};
        tbl[7]  = '{12, 59, 55, 0, 0, 0};
        tbl[8]  = '{12, 59, 56, 1, 0, 1};
        tbl[9]  = '{12, 59, 57, 0, 0, 0};
        tbl[10] = '{12, 59, 58, 1, 0, 1};
        tbl[11] = '{12, 59, 59, 0, 0, 0};
        tbl[12] = '{13,  0,  0, 0, 1, 0};
        tbl[13] = '{13,  0,  1, 0, 0, 0};
        tbl[14] = '{13,  0,  2, 0, 0, 0};

        // Reset held while the time sits on a beep second.
        start_at(12, 59, 50);
        rst = 1'b1;
        step();
        step();
        chk("rst_alarm",  if0.alarm,  1'b0);
        chk("rst_alarm2", if0.alarm2, 1'b0);
        chk("rst_busy",   if0.busy,   1'b0);
        rst = 1'b0;

        // Pre-hour beeps and single top-of-hour pulse.
        sen = 1'b0;
        dang = 1'b1;
        foreach (tbl[i]) begin
            hh = tbl[i].hh; mm = tbl[i].mm; ss = tbl[i].ss;
            step();
            chk($sformatf("tbl%0d_alarm0", i),  if0.alarm,  tbl[i].ea0);
            chk($sformatf("tbl%0d_alarm2_0", i), if0.alarm2, tbl[i].ea2_0);
            chk($sformatf("tbl%0d_alarm_pb3", i), if1.alarm, tbl[i].ea1);
        end

        // Strike mode: 15:00 -> 3, 00:00 -> 12, 12:00 -> 12, invalid hour -> none.
        sen = 1'b1;
        start_at(14, 59, 58);
        run_pulses(300, 4, pulses, bseen);
        chk_int("strike15_pulses", pulses, 3);
        chk("strike15_busy_end", if0.busy, 1'b0);

        start_at(23, 59, 58);
        run_pulses(300, 4, pulses, bseen);
        chk_int("strike00_pulses", pulses, 12);

        start_at(11, 59, 58);
        run_pulses(300, 4, pulses, bseen);
        chk_int("strike12_pulses", pulses, 12);
        chk("strike12_busy_end", if1.busy, 1'b0);

        bad_hr = 1'b1; bad_h1 = 4'd2; bad_h0 = 4'd10;
        start_at(0, 59, 58);
        run_pulses(40, 4, pulses, bseen);
        chk_int("strike2A_pulses", pulses, 0);
        chk("strike2A_busy_seen", bseen, 1'b0);
        bad_hr = 1'b0;

        // Abort during the 5th strike of hour 07.
        start_at(6, 59, 58);
        pulses = 0;
        reached = 0;
        prev = if0.alarm2;
        for (int i = 0; i < 200 && !reached; i++) begin
            walk1(4);
            if (if0.alarm2 && !prev) pulses++;
            prev = if0.alarm2;
            if (pulses == 5) reached = 1;
        end
        chk("abort_reached_5th", reached, 1'b1);
        dang = 1'b0;
        step();
        chk("abort_alarm2", if0.alarm2, 1'b0);
        chk("abort_busy",   if0.busy,   1'b0);
        dang = 1'b1;
        run_pulses(100, 4, more, bseen);
        chk_int("abort_more_pulses", more, 0);

        // Reset mid-strike, then reset during beep second 52.
        start_at(7, 59, 58);
        for (int i = 0; i < 20; i++) walk1(4);
        chk("rst_mid_busy_before", if0.busy, 1'b1);
        rst = 1'b1;
        step();
        chk("rst_mid_alarm2", if0.alarm2, 1'b0);
        chk("rst_mid_busy",   if0.busy,   1'b0);
        chk("rst_mid_busy1",  if1.busy,   1'b0);
        rst = 1'b0;
        sen = 1'b0;
        start_at(12, 59, 52);
        step();
        chk("beep52_alarm", if0.alarm, 1'b1);
        rst = 1'b1;
        step();
        chk("beep52_rst_alarm", if0.alarm, 1'b0);
        rst = 1'b0;
        step();

        // Randomized traffic: time jumps around hour boundaries, ticks, enables, resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            rst = (r < 5);
            if (r >= 5 && r < 20) begin
                hh = int'($urandom_range(0, 23));
                bad_hr = ($urandom_range(0, 7) == 0);
                bad_h1 = 4'($urandom_range(0, 3));
                bad_h0 = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    mm = 59; ss = int'($urandom_range(40, 59));
                end else begin
                    mm = 0; ss = 0;
                end
            end
            if (r >= 20 && r < 30) sen = ~sen;
            if (r >= 30 && r < 36) dang = 1'b0;
            else if (!dang && r < 300) dang = 1'b1;
            tick = ($urandom_range(0, 2) == 0);
            step();
            if (tick) advance();
            tick = 1'b0;
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
